junction_controller: RTL

- Sequences a two-road junction (north-south and east-west) built from two traffic light heads, plus a pedestrian crossing phase.
- Drives UK-style red / red+amber / green / amber sequences with an all-red clearance between the two directions.
- Each phase lasts a parameterised number of clock cycles.
- Serves as the top-level scheduler that owns the light outputs; benches observe the six lamp outputs and the state code.

---
 rtl/junction_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/junction_controller.sv
// Two-road junction light sequencer with pedestrian walk phase; optional night flash via JUNCTION_NIGHT_FLASH_EN.
// Latency: lamps and state are registered and change on the same edge; enable=0 freezes state and dwell counter.
module junction_controller #(
   parameter int unsigned GREEN_CYCLES     = 8,
   parameter int unsigned AMBER_CYCLES     = 2,
   parameter int unsigned RED_AMBER_CYCLES = 2,
   parameter int unsigned ALL_RED_CYCLES   = 1,
   parameter int unsigned WALK_CYCLES      = 6,
   parameter int unsigned CNT_W            = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       ped_req,
`ifdef JUNCTION_NIGHT_FLASH_EN
   input  logic       night,
`endif
   output logic       ns_red,
   output logic       ns_amber,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_amber,
   output logic       ew_green,
   output logic       walk,
   output logic       ped_pending,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      ALLRED_NS = 4'd0,
      NS_RA     = 4'd1,
      NS_G      = 4'd2,
      NS_A      = 4'd3,
      ALLRED_EW = 4'd4,
      EW_RA     = 4'd5,
      EW_G      = 4'd6,
      EW_A      = 4'd7,
      WALK      = 4'd8,
      FLASH     = 4'd9
   } state_t;

   state_t           cur, nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             flash, flash_nxt;
   logic             ped_nxt;
   logic [6:0]       lamps_q, lamps_nxt;
   logic             night_i;

`ifdef JUNCTION_NIGHT_FLASH_EN
   assign night_i = night;
`else
   assign night_i = 1'b0;
`endif

   // A dwell of 0 behaves as 1, so the loaded count never underflows.
   function automatic logic [CNT_W-1:0] load_of(input int unsigned d);
      return (d == 0) ? '0 : CNT_W'(d - 1);
   endfunction

   function automatic logic [CNT_W-1:0] dwell_of(input state_t s);
      case (s)
         NS_RA, EW_RA: return load_of(RED_AMBER_CYCLES);
         NS_G,  EW_G:  return load_of(GREEN_CYCLES);
         NS_A,  EW_A:  return load_of(AMBER_CYCLES);
         WALK:         return load_of(WALK_CYCLES);
         FLASH:        return load_of(AMBER_CYCLES);
         default:      return load_of(ALL_RED_CYCLES);
      endcase
   endfunction

   // Bit order: {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk}
   function automatic logic [6:0] decode(input state_t s, input logic f);
      case (s)
         NS_RA:   return 7'b110_100_0;
         NS_G:    return 7'b001_100_0;
         NS_A:    return 7'b010_100_0;
         EW_RA:   return 7'b100_110_0;
         EW_G:    return 7'b100_001_0;
         EW_A:    return 7'b100_010_0;
         WALK:    return 7'b100_100_1;
         FLASH:   return {1'b0, f, 1'b0, 1'b0, f, 1'b0, 1'b0};
         default: return 7'b100_100_0;
      endcase
   endfunction

   always_comb begin
      nxt       = cur;
      cnt_nxt   = cnt;
      flash_nxt = flash;
      case (cur)
         ALLRED_NS, NS_RA, NS_G, NS_A, ALLRED_EW, EW_RA, EW_G, EW_A, WALK: begin
            if (enable) begin
               if (cnt != '0) begin
                  cnt_nxt = cnt - CNT_W'(1);
               end else if (night_i) begin
                  nxt = FLASH;
               end else begin
                  case (cur)
                     ALLRED_NS: nxt = NS_RA;
                     NS_RA:     nxt = NS_G;
                     NS_G:      nxt = NS_A;
                     NS_A:      nxt = ALLRED_EW;
                     ALLRED_EW: nxt = EW_RA;
                     EW_RA:     nxt = EW_G;
                     EW_G:      nxt = EW_A;
                     EW_A:      nxt = ped_pending ? WALK : ALLRED_NS;
                     default:   nxt = ALLRED_NS;
                  endcase
               end
            end
         end
`ifdef JUNCTION_NIGHT_FLASH_EN
         FLASH: begin
            if (enable) begin
               if (!night_i) begin
                  nxt = ALLRED_NS;
               end else if (cnt != '0) begin
                  cnt_nxt = cnt - CNT_W'(1);
               end else begin
                  flash_nxt = ~flash;
                  cnt_nxt   = dwell_of(FLASH);
               end
            end
         end
`endif
         default: nxt = ALLRED_NS;
      endcase

      if (nxt != cur) begin
         cnt_nxt   = dwell_of(nxt);
         flash_nxt = 1'b1;
      end

      // Entering WALK clears the latch; requests arriving while in WALK are dropped.
      ped_nxt = ped_pending;
      if (cur != WALK) begin
         if (nxt == WALK)  ped_nxt = 1'b0;
         else if (ped_req) ped_nxt = 1'b1;
      end

      lamps_nxt = decode(nxt, flash_nxt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur         <= ALLRED_NS;
         cnt         <= dwell_of(ALLRED_NS);
         flash       <= 1'b1;
         ped_pending <= 1'b0;
         lamps_q     <= 7'b100_100_0;
      end else begin
         cur         <= nxt;
         cnt         <= cnt_nxt;
         flash       <= flash_nxt;
         ped_pending <= ped_nxt;
         lamps_q     <= lamps_nxt;
      end
   end

   assign {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk} = lamps_q;
   assign state = cur;

endmodule
